ram8_bank: RTL and testbench

- 8-word register bank, the sequential consumer of the demultiplexer stage.
- A 1-to-8 demultiplexer steers the single write-enable `load` to exactly one word register, selected by `address`.
- A read multiplexer returns the addressed word.
- Serves as the building block for the larger memories (ram64 and up) in the computer datapath.

---
 rtl/hack_pkg.sv | 10 +
 rtl/dmux.sv | 12 +
 rtl/dmux8way.sv | 32 +++
 rtl/ram8_bank.sv | 54 +++++
 tb/tb_ram8_bank.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// Shared datapath types and constants for the register and memory blocks.
package hack_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR8_W = 3;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [ADDR8_W-1:0] addr8_t;

endpackage : hack_pkg

// File: rtl/dmux.sv
// 1-to-2 demultiplexer: routes in to a when sel=0, to b when sel=1.
module dmux (
  input  logic in,
  input  logic sel,
  output logic a,
  output logic b
);

  assign a = in & ~sel;
  assign b = in &  sel;

endmodule : dmux

// File: rtl/dmux8way.sv
// 1-to-8 demultiplexer built as a three-level tree of dmux cells; output is one-hot or zero.
module dmux8way
  import hack_pkg::*;
(
  input  logic   in,
  input  addr8_t sel,
  output logic   a,
  output logic   b,
  output logic   c,
  output logic   d,
  output logic   e,
  output logic   f,
  output logic   g,
  output logic   h
);

  logic       hi_lo_0;
  logic       hi_lo_1;
  logic [3:0] mid;

  // sel[2] picks the half, sel[1] the quarter, sel[0] the word.
  dmux u_top (.in(in), .sel(sel[2]), .a(hi_lo_0), .b(hi_lo_1));

  dmux u_mid0 (.in(hi_lo_0), .sel(sel[1]), .a(mid[0]), .b(mid[1]));
  dmux u_mid1 (.in(hi_lo_1), .sel(sel[1]), .a(mid[2]), .b(mid[3]));

  dmux u_leaf0 (.in(mid[0]), .sel(sel[0]), .a(a), .b(b));
  dmux u_leaf1 (.in(mid[1]), .sel(sel[0]), .a(c), .b(d));
  dmux u_leaf2 (.in(mid[2]), .sel(sel[0]), .a(e), .b(f));
  dmux u_leaf3 (.in(mid[3]), .sel(sel[0]), .a(g), .b(h));

endmodule : dmux8way

// File: rtl/ram8_bank.sv
// Eight-word register bank: one-hot write decode of load, combinational read of word[address].
module ram8_bank
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH  = WORD_W,
  parameter int unsigned ADDR_W = $bits(addr8_t)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  out,
  output logic [7:0]        written
);

  localparam int unsigned DEPTH = 8;

  logic [WIDTH-1:0] word [DEPTH];
  logic [DEPTH-1:0] load_k;

  dmux8way u_dmux (
    .in  (load),
    .sel (addr8_t'(address)),
    .a   (load_k[0]),
    .b   (load_k[1]),
    .c   (load_k[2]),
    .d   (load_k[3]),
    .e   (load_k[4]),
    .f   (load_k[5]),
    .g   (load_k[6]),
    .h   (load_k[7])
  );

  // Reset wins over any write in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        word[k] <= '0;
      end
      written <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (load_k[k]) begin
          word[k]    <= in;
          written[k] <= 1'b1;
        end
      end
    end
  end

  assign out = word[addr8_t'(address)];

endmodule : ram8_bank

// File: tb/tb_ram8_bank.sv
// Directed self-checking bench for ram8_bank.
module tb_ram8_bank;

  logic        clock;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic [15:0] out;
  logic [7:0]  written;

  int n_checks;
  int n_fail;

  ram8_bank dut (
    .clock   (clock),
    .reset   (reset),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out),
    .written (written)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic write_word(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      n_checks++;
      if (out !== 16'h0000) begin
        $display("FAIL reset_out addr=%0d got=%h exp=0000", a, out);
        n_fail++;
      end
    end
    n_checks++;
    if (written !== 8'h00) begin
      $display("FAIL reset_written got=%h exp=00", written);
      n_fail++;
    end
  endtask

  task automatic test_write_all();
    logic [7:0]  exp_w;
    logic [15:0] exp_d;
    do_reset();
    exp_w = 8'h00;
    for (int k = 0; k < 8; k++) begin
      write_word(3'(k), 16'h1000 + 16'(k));
      exp_w = exp_w | 8'(1 << k);
      n_checks++;
      if (written !== exp_w) begin
        $display("FAIL write_all_written step=%0d got=%h exp=%h", k, written, exp_w);
        n_fail++;
      end
      for (int a = 0; a < 8; a++) begin
        address = 3'(a);
        #1;
        exp_d = (a <= k) ? 16'h1000 + 16'(a) : 16'h0000;
        n_checks++;
        if (out !== exp_d) begin
          $display("FAIL write_all_read step=%0d addr=%0d got=%h exp=%h", k, a, out, exp_d);
          n_fail++;
        end
      end
    end
    n_checks++;
    if (written !== 8'hFF) begin
      $display("FAIL write_all_final_written got=%h exp=ff", written);
      n_fail++;
    end
  endtask

  task automatic test_latency();
    do_reset();
    address = 3'd3;
    in      = 16'hBEEF;
    load    = 1'b1;
    #1;
    n_checks++;
    if (out !== 16'h0000) begin
      $display("FAIL latency_before got=%h exp=0000", out);
      n_fail++;
    end
    tick();
    n_checks++;
    if (out !== 16'hBEEF) begin
      $display("FAIL latency_after got=%h exp=beef", out);
      n_fail++;
    end
    load = 1'b0;
    in   = 16'h1234;
    tick();
    n_checks++;
    if (out !== 16'hBEEF) begin
      $display("FAIL latency_hold got=%h exp=beef", out);
      n_fail++;
    end
    n_checks++;
    if (written !== 8'h08) begin
      $display("FAIL latency_written got=%h exp=08", written);
      n_fail++;
    end
  endtask

  task automatic test_decode_isolation();
    do_reset();
    write_word(3'd5, 16'hAAAA);
    address = 3'd4;
    #1;
    n_checks++;
    if (out !== 16'h0000) begin
      $display("FAIL iso_addr4 got=%h exp=0000", out);
      n_fail++;
    end
    address = 3'd6;
    #1;
    n_checks++;
    if (out !== 16'h0000) begin
      $display("FAIL iso_addr6 got=%h exp=0000", out);
      n_fail++;
    end
    address = 3'd5;
    #1;
    n_checks++;
    if (out !== 16'hAAAA) begin
      $display("FAIL iso_addr5 got=%h exp=aaaa", out);
      n_fail++;
    end
    n_checks++;
    if (written !== 8'b0010_0000) begin
      $display("FAIL iso_written got=%h exp=20", written);
      n_fail++;
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    write_word(3'd2, 16'h9999);
    address = 3'd2;
    in      = 16'h5555;
    load    = 1'b1;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    load    = 1'b0;
    #1;
    n_checks++;
    if (out !== 16'h0000) begin
      $display("FAIL prio_out got=%h exp=0000", out);
      n_fail++;
    end
    n_checks++;
    if (written !== 8'h00) begin
      $display("FAIL prio_written got=%h exp=00", written);
      n_fail++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    write_word(3'd7, 16'h7777);
    do_reset();
    write_word(3'd0, 16'h0001);
    address = 3'd7;
    #1;
    n_checks++;
    if (out !== 16'h0000) begin
      $display("FAIL mid_addr7 got=%h exp=0000", out);
      n_fail++;
    end
    address = 3'd0;
    #1;
    n_checks++;
    if (out !== 16'h0001) begin
      $display("FAIL mid_addr0 got=%h exp=0001", out);
      n_fail++;
    end
    n_checks++;
    if (written !== 8'h01) begin
      $display("FAIL mid_written got=%h exp=01", written);
      n_fail++;
    end
  endtask

  task automatic test_rewrite();
    do_reset();
    write_word(3'd1, 16'h1111);
    write_word(3'd1, 16'h2222);
    address = 3'd1;
    #1;
    n_checks++;
    if (out !== 16'h2222) begin
      $display("FAIL rewrite_out got=%h exp=2222", out);
      n_fail++;
    end
    n_checks++;
    if (written !== 8'h02) begin
      $display("FAIL rewrite_written got=%h exp=02", written);
      n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    load     = 1'b0;
    in       = 16'h0000;
    address  = 3'd0;
    #2;
    test_reset();
    test_write_all();
    test_latency();
    test_decode_isolation();
    test_reset_priority();
    test_mid_reset();
    test_rewrite();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ram8_bank
